// File: rtl/sdram_port_arbiter.sv
// N-port request arbiter in front of the single enable/valid port of sdramController.
// One outstanding transaction; fixed-priority or round-robin selection.
module sdram_port_arbiter #(
   parameter int unsigned NUM_PORTS = 2,
   parameter int unsigned ADDR_W    = 25,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned RR_MODE   = 0,
   localparam int unsigned GW       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_PORTS-1:0]        req_enable,
   input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
   input  logic [NUM_PORTS*2-1:0]      req_oplen,
   input  logic [NUM_PORTS*DATA_W-1:0] req_wdata,
   input  logic [NUM_PORTS-1:0]        req_rw,
   output logic [NUM_PORTS-1:0]        req_valid,
   output logic [DATA_W-1:0]           req_rdata,
   output logic [GW-1:0]               grant_idx,
   output logic                        busy,
   output logic                        mem_enable,
   output logic [ADDR_W-1:0]           mem_addr,
   output logic [1:0]                  mem_oplen,
   output logic [DATA_W-1:0]           mem_wdata,
   output logic                        mem_rw,
   input  logic                        mem_valid,
   input  logic [DATA_W-1:0]           mem_rdata
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]    state;
   logic [GW-1:0] ptr;
   logic [GW-1:0] win;
   logic          hit;
   int unsigned   k;

   // Round robin searches upward from the port after the last winner, wrapping.
   always_comb begin
      win = '0;
      hit = 1'b0;
      k   = 0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         if (RR_MODE != 0)
            k = (32'(ptr) + i + 1) % NUM_PORTS;
         else
            k = i;
         if (!hit && req_enable[GW'(k)]) begin
            hit = 1'b1;
            win = GW'(k);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         ptr        <= GW'(NUM_PORTS - 1);
         grant_idx  <= '0;
         busy       <= 1'b0;
         mem_enable <= 1'b0;
         mem_addr   <= '0;
         mem_oplen  <= '0;
         mem_wdata  <= '0;
         mem_rw     <= 1'b0;
         req_valid  <= '0;
         req_rdata  <= '0;
      end else begin
         req_valid <= '0;
         case (state)
            IDLE: begin
               if (hit) begin
                  mem_addr   <= req_addr[32'(win)*ADDR_W +: ADDR_W];
                  mem_oplen  <= req_oplen[32'(win)*2 +: 2];
                  mem_wdata  <= req_wdata[32'(win)*DATA_W +: DATA_W];
                  mem_rw     <= req_rw[win];
                  grant_idx  <= win;
                  ptr        <= win;
                  mem_enable <= 1'b1;
                  busy       <= 1'b1;
                  state      <= BUSY;
               end
            end
            BUSY: begin
               if (mem_valid) begin
                  req_rdata  <= mem_rdata;
                  req_valid  <= NUM_PORTS'(1) << grant_idx;
                  mem_enable <= 1'b0;
                  state      <= DONE;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               mem_enable <= 1'b0;
               busy       <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed checks of sdram_port_arbiter: 2-port fixed priority vector table plus
// hand-written write-hold, async reset, request pulse and 4-port round-robin sequences.
module tb_sdram_port_arbiter;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // 2-port fixed-priority instance
   logic [1:0]  req_enable = '0;
   logic [49:0] req_addr   = {25'h20, 25'h10};
   logic [3:0]  req_oplen  = 4'b1001;
   logic [63:0] req_wdata  = '0;
   logic [1:0]  req_rw     = '0;
   logic [1:0]  req_valid;
   logic [31:0] req_rdata;
   logic        grant_idx;
   logic        busy;
   logic        mem_enable;
   logic [24:0] mem_addr;
   logic [1:0]  mem_oplen;
   logic [31:0] mem_wdata;
   logic        mem_rw;
   logic        mem_valid = 1'b0;
   logic [31:0] mem_rdata = 32'hDEADBEEF;

   sdram_port_arbiter #(.NUM_PORTS(2), .ADDR_W(25), .DATA_W(32), .RR_MODE(0)) dut (
      .clk(clk), .rst_n(rst_n), .req_enable(req_enable), .req_addr(req_addr),
      .req_oplen(req_oplen), .req_wdata(req_wdata), .req_rw(req_rw),
      .req_valid(req_valid), .req_rdata(req_rdata), .grant_idx(grant_idx),
      .busy(busy), .mem_enable(mem_enable), .mem_addr(mem_addr),
      .mem_oplen(mem_oplen), .mem_wdata(mem_wdata), .mem_rw(mem_rw),
      .mem_valid(mem_valid), .mem_rdata(mem_rdata));

   // 4-port round-robin instance
   logic [3:0]   rr_req_enable = '0;
   logic [99:0]  rr_req_addr   = {25'h103, 25'h102, 25'h101, 25'h100};
   logic [7:0]   rr_req_oplen  = '0;
   logic [127:0] rr_req_wdata  = '0;
   logic [3:0]   rr_req_rw     = '0;
   logic [3:0]   rr_req_valid;
   logic [31:0]  rr_req_rdata;
   logic [1:0]   rr_grant_idx;
   logic         rr_busy;
   logic         rr_mem_enable;
   logic [24:0]  rr_mem_addr;
   logic [1:0]   rr_mem_oplen;
   logic [31:0]  rr_mem_wdata;
   logic         rr_mem_rw;
   logic         rr_mem_valid = 1'b0;
   logic [31:0]  rr_mem_rdata = '0;

   sdram_port_arbiter #(.NUM_PORTS(4), .ADDR_W(25), .DATA_W(32), .RR_MODE(1)) dut_rr (
      .clk(clk), .rst_n(rst_n), .req_enable(rr_req_enable), .req_addr(rr_req_addr),
      .req_oplen(rr_req_oplen), .req_wdata(rr_req_wdata), .req_rw(rr_req_rw),
      .req_valid(rr_req_valid), .req_rdata(rr_req_rdata), .grant_idx(rr_grant_idx),
      .busy(rr_busy), .mem_enable(rr_mem_enable), .mem_addr(rr_mem_addr),
      .mem_oplen(rr_mem_oplen), .mem_wdata(rr_mem_wdata), .mem_rw(rr_mem_rw),
      .mem_valid(rr_mem_valid), .mem_rdata(rr_mem_rdata));

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [1:0]  en;
      logic        mv;
      logic        men;
      logic [1:0]  vld;
      logic        bsy;
      logic        gidx;
      logic [24:0] addr;
      logic [31:0] rdata;
   } vec_t;

   vec_t tbl[16];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // en, mv | men, vld, busy, gidx, addr, rdata (sampled just after the edge)
      tbl[0]  = '{2'b01, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 25'h10, 32'h0};
      tbl[1]  = '{2'b01, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 25'h10, 32'h0};
      tbl[2]  = '{2'b01, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 25'h10, 32'h0};
      tbl[3]  = '{2'b01, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 25'h10, 32'h0};
      tbl[4]  = '{2'b01, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 25'h10, 32'h0};
      tbl[5]  = '{2'b01, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 25'h10, 32'hDEADBEEF};
      tbl[6]  = '{2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 25'h10, 32'hDEADBEEF};
      tbl[7]  = '{2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 25'h10, 32'hDEADBEEF};
      tbl[8]  = '{2'b11, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 25'h10, 32'hDEADBEEF};
      tbl[9]  = '{2'b11, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 25'h10, 32'hDEADBEEF};
      tbl[10] = '{2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 25'h10, 32'hDEADBEEF};
      tbl[11] = '{2'b10, 1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 25'h20, 32'hDEADBEEF};
      tbl[12] = '{2'b10, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 25'h20, 32'hDEADBEEF};
      tbl[13] = '{2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 25'h20, 32'hDEADBEEF};
      tbl[14] = '{2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 25'h20, 32'hDEADBEEF};
      tbl[15] = '{2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 25'h20, 32'hDEADBEEF};

      // reset state
      step(); step();
      chk("rst_mem_enable", mem_enable, 0);
      chk("rst_req_valid", req_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_grant_idx", grant_idx, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_req_rdata", req_rdata, 0);
      chk("rst_rr_grant_idx", rr_grant_idx, 0);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         req_enable = tbl[i].en;
         mem_valid  = tbl[i].mv;
         step();
         chk($sformatf("vec%0d_mem_enable", i), mem_enable, tbl[i].men);
         chk($sformatf("vec%0d_req_valid", i), req_valid, tbl[i].vld);
         chk($sformatf("vec%0d_busy", i), busy, tbl[i].bsy);
         chk($sformatf("vec%0d_grant_idx", i), grant_idx, tbl[i].gidx);
         chk($sformatf("vec%0d_mem_addr", i), mem_addr, tbl[i].addr);
         chk($sformatf("vec%0d_req_rdata", i), req_rdata, tbl[i].rdata);
         chk($sformatf("vec%0d_mem_rw", i), mem_rw, 0);
      end
      req_enable = '0;
      mem_valid  = 1'b0;

      // port1 write; fields must hold while request inputs change during BUSY
      req_addr[49:25]  = 25'h8;
      req_wdata[63:32] = 32'hFEEF;
      req_rw           = 2'b10;
      req_oplen        = 4'b1101;
      req_enable       = 2'b10;
      step();
      chk("wr_mem_enable", mem_enable, 1);
      chk("wr_grant_idx", grant_idx, 1);
      chk("wr_mem_oplen", mem_oplen, 2'b11);
      req_addr[49:25]  = 25'h1F0;
      req_wdata[63:32] = 32'h0;
      req_rw           = 2'b00;
      req_enable       = 2'b11;
      step(); step();
      chk("wr_hold_addr", mem_addr, 25'h8);
      chk("wr_hold_wdata", mem_wdata, 32'hFEEF);
      chk("wr_hold_rw", mem_rw, 1);
      chk("wr_hold_grant", grant_idx, 1);
      mem_valid  = 1'b1;
      mem_rdata  = 32'h0000CAFE;
      step();
      mem_valid  = 1'b0;
      req_enable = 2'b00;
      chk("wr_req_valid", req_valid, 2'b10);
      chk("wr_req_rdata", req_rdata, 32'h0000CAFE);
      chk("wr_final_addr", mem_addr, 25'h8);
      step(); step();
      chk("wr_idle_enable", mem_enable, 0);

      // asynchronous reset mid-BUSY
      req_addr[24:0] = 25'h10;
      req_rw         = 2'b00;
      req_enable     = 2'b01;
      step();
      chk("ar_granted", mem_enable, 1);
      req_enable = 2'b00;
      #3;
      rst_n = 1'b0;
      #1;
      chk("ar_mem_enable", mem_enable, 0);
      chk("ar_busy", busy, 0);
      chk("ar_req_valid", req_valid, 0);
      chk("ar_mem_addr", mem_addr, 0);
      #2;
      rst_n = 1'b1;
      step(); step(); step();
      chk("ar_stay_idle", mem_enable, 0);
      chk("ar_stay_busy", busy, 0);
      mem_valid = 1'b1;
      step();
      mem_valid = 1'b0;
      chk("ar_late_valid", req_valid, 0);
      step();
      chk("ar_late_valid2", req_valid, 0);

      // request pulse withdrawn before the sampling edge
      req_enable = 2'b01;
      #3;
      req_enable = 2'b00;
      step();
      chk("pulse_mem_enable", mem_enable, 0);
      chk("pulse_busy", busy, 0);
      step();
      chk("pulse_req_valid", req_valid, 0);

      // 4-port round robin with all ports requesting continuously
      rr_req_enable = 4'b1111;
      for (int t = 0; t < 6; t++) begin
         int w;
         w = 0;
         while (rr_mem_enable !== 1'b1 && w < 20) begin
            step();
            w++;
         end
         chk($sformatf("rr%0d_enable_seen", t), rr_mem_enable, 1);
         chk($sformatf("rr%0d_grant_idx", t), rr_grant_idx, t % 4);
         chk($sformatf("rr%0d_mem_addr", t), rr_mem_addr, 25'h100 + t % 4);
         step(); step();
         rr_mem_valid = 1'b1;
         rr_mem_rdata = 32'hA000 + t;
         step();
         rr_mem_valid = 1'b0;
         chk($sformatf("rr%0d_req_valid", t), rr_req_valid, 4'b0001 << (t % 4));
         chk($sformatf("rr%0d_req_rdata", t), rr_req_rdata, 32'hA000 + t);
      end
      rr_req_enable = '0;
      step(); step(); step();
      chk("rr_final_idle", rr_mem_enable, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
